// File: rtl/dmem_lsu_bridge_if.sv
// rtl/dmem_lsu_bridge_if.sv - CPU load/store and SRAM port bundle for dmem_lsu_bridge
// slave is the bridge view; master is the CPU/SRAM side.
interface dmem_lsu_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [7:0]  err_count;

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wdata, mem_wstrb, err_count
  );

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wdata, mem_wstrb, err_count
  );
endinterface

// File: rtl/dmem_lsu_bridge.sv
// rtl/dmem_lsu_bridge.sv - single-outstanding CPU load/store to SRAM bridge with lane steering
// Define DMEM_BOUNDS_CHECK_EN to flag addresses outside the 0x1000_xxxx window as errors.
module dmem_lsu_bridge (
  input  logic               clk,
  input  logic               rst,
  dmem_lsu_bridge_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        illegal;
  logic        accept;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic        unused_addr_hi;

  assign accept         = (state_q == IDLE) && bus.req_valid;
  assign unused_addr_hi = ^addr_q[31:16];

  always_comb begin
    illegal = 1'b0;
    case (bus.req_size)
      2'd0:    illegal = 1'b0;
      2'd1:    illegal = bus.req_addr[0];
      2'd2:    illegal = |bus.req_addr[1:0];
      default: illegal = 1'b1;
    endcase
`ifdef DMEM_BOUNDS_CHECK_EN
    if (bus.req_addr[31:16] != 16'h1000) begin
      illegal = 1'b1;
    end
`endif
  end

  // Load lane steering and extension from the combinational SRAM read.
  always_comb begin
    lane_b = bus.mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0: begin
        strb      = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        strb      = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = illegal ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture; response registers then hold until the next accept.
  always_comb begin
    addr_d    = addr_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      addr_d  = bus.req_addr;
      we_d    = bus.req_we;
      size_d  = bus.req_size;
      uns_d   = bus.req_unsigned;
      wdata_d = bus.req_wdata;
      rdata_d = 32'd0;
      err_d   = illegal;
      if (illegal && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (state_q == ACCESS) begin
      rdata_d = we_q ? 32'd0 : load_ext;
    end
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.mem_we    = (state_q == ACCESS) && we_q && !rst;
    bus.mem_wstrb = ((state_q == ACCESS) && we_q) ? strb : 4'b0000;
    bus.mem_addr  = addr_q[15:2];
    bus.mem_wdata = wdata_rep;
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.err_count = err_cnt_q;
  end

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// tb/tb_dmem_lsu_bridge.sv - directed self-checking bench for dmem_lsu_bridge with a byte-strobed SRAM model
module tb_dmem_lsu_bridge;
  logic clk;
  logic rst;
  logic mem_clear;
  int   n_chk;
  int   n_err;
  int   exp_errs;
  int   we_cnt;
  logic [13:0] last_addr;
  logic [3:0]  last_strb;
  logic [31:0] last_wdata;
  logic [31:0] sram [0:16383];

  dmem_lsu_bridge_if bus ();

  dmem_lsu_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = sram[bus.mem_addr];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16384; i++) sram[i] <= 32'd0;
    end else if (bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wstrb[b]) sram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      we_cnt     <= we_cnt + 1;
      last_addr  <= bus.mem_addr;
      last_strb  <= bus.mem_wstrb;
      last_wdata <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input logic exp_err, input logic [31:0] exp_rdata);
    int          lat;
    int          we0;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    we0 = we_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    check({tag, "_rsp_err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, "_rsp_rdata"}, rd, exp_rdata);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, bus.rsp_rdata, rd);
      check({tag, "_hold_err"}, {31'd0, bus.rsp_err}, {31'd0, er});
      check({tag, "_hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check({tag, "_we_pulses"}, 32'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
    if (exp_err && exp_errs < 255) exp_errs++;
    check({tag, "_err_count"}, {24'd0, bus.err_count}, 32'(exp_errs));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_errs = 0;
    we_cnt = 0;
    last_addr = '0;
    last_strb = '0;
    last_wdata = '0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    mem_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    rst = 1'b0;
    mem_clear = 1'b0;

    do_req("st_word", 1'b1, 2'd2, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'd0);
    check("st_word_addr", {18'd0, last_addr}, 32'd4);
    check("st_word_strb", {28'd0, last_strb}, 32'hF);
    check("st_word_wdata", last_wdata, 32'hDEAD_BEEF);

    do_req("st_byte", 1'b1, 2'd0, 1'b0, 32'h1000_0013, 32'h0000_00A5, 0, 1'b0, 32'd0);
    check("st_byte_strb", {28'd0, last_strb}, 32'h8);
    check("st_byte_wdata", last_wdata, 32'hA5A5_A5A5);

    do_req("st_half", 1'b1, 2'd1, 1'b0, 32'h1000_0016, 32'h0000_1234, 0, 1'b0, 32'd0);
    check("st_half_strb", {28'd0, last_strb}, 32'hC);
    check("st_half_wdata", last_wdata, 32'h1234_1234);
    check("st_half_addr", {18'd0, last_addr}, 32'd5);

    do_req("ld_word", 1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'd0, 0, 1'b0, 32'hA5AD_BEEF);
    do_req("ld_sb", 1'b0, 2'd0, 1'b0, 32'h1000_0013, 32'd0, 0, 1'b0, 32'hFFFF_FFA5);
    do_req("ld_ub", 1'b0, 2'd0, 1'b1, 32'h1000_0013, 32'd0, 0, 1'b0, 32'h0000_00A5);
    do_req("ld_sh", 1'b0, 2'd1, 1'b0, 32'h1000_0012, 32'd0, 0, 1'b0, 32'hFFFF_A5AD);
    do_req("ld_uh_lo", 1'b0, 2'd1, 1'b1, 32'h1000_0010, 32'd0, 0, 1'b0, 32'h0000_BEEF);
    do_req("ld_sb1", 1'b0, 2'd0, 1'b0, 32'h1000_0011, 32'd0, 0, 1'b0, 32'hFFFF_FFBE);
    do_req("ld_ub0", 1'b0, 2'd0, 1'b0, 32'h1000_0010, 32'd0, 0, 1'b0, 32'hFFFF_FFEF);
    do_req("ld_uh_st", 1'b0, 2'd1, 1'b0, 32'h1000_0016, 32'd0, 0, 1'b0, 32'h0000_1234);

    do_req("err_ld_mis", 1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'd0, 0, 1'b1, 32'd0);
    do_req("err_st_mis", 1'b1, 2'd2, 1'b0, 32'h1000_0011, 32'h1111_1111, 0, 1'b1, 32'd0);
    do_req("err_size3", 1'b1, 2'd3, 1'b0, 32'h1000_0010, 32'h2222_2222, 0, 1'b1, 32'd0);
    do_req("err_half_odd", 1'b1, 2'd1, 1'b0, 32'h1000_0013, 32'h3333_3333, 0, 1'b1, 32'd0);
    do_req("ld_after_err", 1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'd0, 0, 1'b0, 32'hA5AD_BEEF);

`ifdef DMEM_BOUNDS_CHECK_EN
    do_req("oob_load", 1'b0, 2'd2, 1'b0, 32'h2000_0000, 32'd0, 0, 1'b1, 32'd0);
`else
    do_req("alias_load", 1'b0, 2'd2, 1'b0, 32'h2000_0010, 32'd0, 0, 1'b0, 32'hA5AD_BEEF);
`endif

    do_req("hold_ld", 1'b0, 2'd0, 1'b1, 32'h1000_0012, 32'd0, 5, 1'b0, 32'h0000_00AD);

    for (int k = 0; k < 255; k++) begin
      do_req("sat", 1'b0, 2'd3, 1'b0, 32'h1000_0000, 32'd0, 0, 1'b1, 32'd0);
    end
    check("sat_err_count", {24'd0, bus.err_count}, 32'd255);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h1000_0020;
    bus.req_wdata = 32'h1234_5678;
    begin
      int we0;
      we0 = we_cnt;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_access_mem_we", {31'd0, bus.mem_we}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_access_no_write", 32'(we_cnt - we0), 32'd0);
    end
    check("rst_access_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_access_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_access_err_count", {24'd0, bus.err_count}, 32'd0);
    exp_errs = 0;
    do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h1000_0020, 32'd0, 0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
